rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
//  Load/store unit between the core execute stage and the 64-bit word data memory (sync write, 1-cycle sync read, no byte enables).
//  Accepts one byte-addressed RV64 load/store at a time; does alignment checks, sub-word extract + sign/zero extension,
//  and read-modify-write for SB/SH/SW (memory writes whole words only). Stalls the core via req_ready.
// PARAMETERS
//  XLEN    64  data width; fixed at 64 (memory word width)
//  ADDR_W  16  memory word-address width; mem_addr = req_addr[ADDR_W+2:3]; higher address bits ignored (wrap)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous reset, active high
//  req_valid    in   1       request present
//  req_ready    out  1       = (state==IDLE) && !rst; request accepted when valid&&ready
//  req_we       in   1       1=store, 0=load
//  req_funct3   in   3       RV funct3: loads LB/LH/LW/LD/LBU/LHU/LWU = 0..6; stores SB/SH/SW/SD = 0..3
//  req_addr     in   64      byte address
//  req_wdata    in   64      store data; low 8/16/32/64 bits used
//  resp_valid   out  1       1-cycle pulse: request completed
//  resp_rdata   out  64      load result (extended); 0 for stores and errors; held until next resp
//  resp_err     out  1       valid with resp_valid: misaligned or illegal funct3
//  mem_addr     out  ADDR_W  word address to data memory
//  mem_wdata    out  64      full word to write
//  mem_wr_en    out  1       write strobe; forced 0 while rst=1
//  mem_rdata    in   64      memory read data, valid the cycle after mem_addr presented with mem_wr_en=0
// BEHAVIOUR
//  Reset: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, captured request cleared.
//  States: IDLE, RD (drive addr, wr_en=0), CAP (mem_rdata valid: extract or merge into register), WR (wr_en=1).
//  On accept in IDLE (cycle T), request is registered; next state:
//   error (misaligned: H off[0]!=0, W off[1:0]!=0, D off[2:0]!=0; illegal: load f3=7, store f3>3) -> IDLE, resp at T+1, err=1, no mem access
//   load -> RD(T+1) -> CAP(T+2) -> IDLE; resp_valid at T+3 with rdata
//   SD   -> WR(T+1) -> IDLE; resp_valid at T+2
//   SB/SH/SW -> RD(T+1) -> CAP(T+2, merged word registered) -> WR(T+3) -> IDLE; resp_valid at T+4
//  Extract: field = mem_rdata >> (8*off); LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD passthrough.
//  Merge: replace only the addressed 8/16/32 bits of mem_rdata with low bits of req_wdata; other bytes unchanged.
//  mem_addr held at captured word address during RD/CAP/WR; mem_wdata = req_wdata (SD) or merged word.
//  resp_valid asserts in the IDLE cycle after completion; a new request may be accepted in that same cycle.
//  req_valid while !req_ready is ignored (core must hold it); no internal queue.
//  Reset mid-operation: operation abandoned, no write issued (wr_en gated by !rst), no resp_valid for it.
// STRUCTURE
//  rv_lsu_pkg: funct3 localparams (F3_B,F3_H,F3_W,F3_D,F3_BU,F3_HU,F3_WU), lsu_state_t enum {IDLE,RD,CAP,WR}.
//  Sub-module rv_lsu_align (combinational): extract(rdata,off,f3)->64b and merge(rdata,wdata,off,f3)->64b; FSM stays in rv_lsu.
// TESTING
//  Bench pairs rv_lsu with a behavioural 1-cycle-read word memory; checks every req/resp cycle count.
//  1 LD addr 0x10, mem[2]=0x8877665544332211 -> resp at T+3, rdata=0x8877665544332211, err=0, no write.
//  2 LB/LBU addr 0x17 on same word -> LB rdata=0xFFFFFFFFFFFFFF88, LBU rdata=0x88.
//  3 SH addr 0x12 wdata=0xABCD -> single wr_en pulse at T+3, mem[2]=0x88776655ABCD2211, resp at T+4.
//  4 LW addr 0x06 -> resp at T+1, err=1, rdata=0, mem_wr_en never high; load f3=7 -> same.
//  5 SD addr 0x18 back-to-back with LD 0x18 accepted in SD resp cycle -> LD returns stored data.
//  6 rst asserted during SB's CAP or WR cycle -> no write, mem unchanged, req_ready=1 after release, no resp.

Source files
------------

// File: rtl/rv_lsu_pkg.sv
// Shared types and constants for the RV64 load/store unit.
package rv_lsu_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ADDR_W_DEF = 16;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} lsu_state_t;

  // Misaligned access or an unencodable funct3 for the given direction.
  function automatic logic lsu_req_err(input logic we, input logic [2:0] f3,
                                       input logic [2:0] off);
    logic illegal;
    logic misal;
    illegal = we ? (f3 > F3_D) : (f3 == 3'd7);
    case (f3[1:0])
      2'd1:    misal = off[0];
      2'd2:    misal = |off[1:0];
      2'd3:    misal = |off;
      default: misal = 1'b0;
    endcase
    return illegal | misal;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Sub-word datapath: load extraction with sign/zero extension and store merge into a full word.
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      f3_i,
  output logic [XLEN-1:0] ext_o,
  output logic [XLEN-1:0] merged_o
);

  logic [5:0]      sh_amt;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] mask_sh;
  logic [XLEN-1:0] wdata_sh;

  assign sh_amt = {off_i, 3'b000};
  assign field  = rdata_i >> sh_amt;

  always_comb begin
    ext_o = field;
    case (f3_i)
      F3_B:    ext_o = {{56{field[7]}}, field[7:0]};
      F3_H:    ext_o = {{48{field[15]}}, field[15:0]};
      F3_W:    ext_o = {{32{field[31]}}, field[31:0]};
      F3_BU:   ext_o = {56'd0, field[7:0]};
      F3_HU:   ext_o = {48'd0, field[15:0]};
      F3_WU:   ext_o = {32'd0, field[31:0]};
      default: ext_o = field;
    endcase
  end

  // Byte-lane mask for the store size, moved up to the addressed offset.
  always_comb begin
    mask = '1;
    case (f3_i[1:0])
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
  end

  assign mask_sh  = mask << sh_amt;
  assign wdata_sh = wdata_i << sh_amt;
  assign merged_o = (rdata_i & ~mask_sh) | (wdata_sh & mask_sh);

endmodule

// File: rtl/rv_lsu.sv
// RV64 load/store unit: one request at a time, read-modify-write for narrow stores.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_wr_en,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [2:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [XLEN-1:0]   ext;
  logic [XLEN-1:0]   merged;
  logic              unused_addr_hi;

  // Address bits above the memory word space wrap silently.
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+3];

  rv_lsu_align u_align (
    .rdata_i  (mem_rdata),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .f3_i     (f3_q),
    .ext_o    (ext),
    .merged_o (merged)
  );

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wr_en  = (state_q == WR) && !rst;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[2:0];
          addr_d  = req_addr[ADDR_W+2:3];
          wdata_d = req_wdata;
          if (lsu_req_err(req_we, req_funct3, req_addr[2:0])) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && (req_funct3 == F3_D)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ext;
          state_d      = IDLE;
        end
      end
      WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu against a behavioural 1-cycle-read word memory.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr_en;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:65535];
  bit          mem_init = 1'b1;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_wr_cyc = -1;
  int          n_cmp = 0;
  int          n_mis = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sbq[$];

  rv_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr_en  (mem_wr_en),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory plus write/cycle bookkeeping; cyc holds the index of the current cycle.
  always @(posedge clk) begin
    if (mem_init) begin
      mem[2] <= 64'h8877_6655_4433_2211;
      mem[3] <= 64'h0;
      mem[4] <= 64'h0123_4567_89AB_CDEF;
      mem[5] <= 64'h5555_AAAA_5555_AAAA;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
    if (mem_wr_en) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: pop the oldest expectation and compare data, error and latency.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check_val("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("resp_err", 64'(resp_err), 64'(e.err));
        check_val("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee,
                       input int lat, input bit push, output int acc);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_val("ready_timeout", 64'(req_ready), 64'd1);
    acc = cyc;
    if (push) sbq.push_back('{rdata: er, err: ee, due: cyc + lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic reset_during(input int stage);
    int acc;
    int w0;
    logic [63:0] m0;
    w0 = wr_cnt;
    m0 = mem[5];
    issue(1'b1, 3'd0, 64'h2B, 64'hC3, 64'd0, 1'b0, 0, 1'b0, acc);
    while (cyc < acc + stage) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("wr_en_in_rst", 64'(mem_wr_en), 64'd0);
    check_val("ready_in_rst", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    check_val("rst_no_write", 64'(wr_cnt), 64'(w0));
    check_val("rst_mem_kept", mem[5], m0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0;
    int a1;
    int w0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    repeat (3) @(negedge clk);
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_resp_err", 64'(resp_err), 64'd0);
    check_val("rst_resp_rdata", resp_rdata, 64'd0);
    check_val("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_val("rst_mem_wdata", mem_wdata, 64'd0);
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    mem_init = 1'b0;
    rst = 1'b0;
    #1 check_val("ready_out_of_rst", 64'(req_ready), 64'd1);

    // Loads of each width from the same word.
    w0 = wr_cnt;
    issue(1'b0, 3'd3, 64'h10, 64'd0, 64'h8877_6655_4433_2211, 1'b0, 3, 1'b1, a0);
    issue(1'b0, 3'd0, 64'h17, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 3, 1'b1, a0);
    issue(1'b0, 3'd4, 64'h17, 64'd0, 64'h0000_0000_0000_0088, 1'b0, 3, 1'b1, a0);
    issue(1'b0, 3'd1, 64'h12, 64'd0, 64'h0000_0000_0000_4433, 1'b0, 3, 1'b1, a0);
    issue(1'b0, 3'd2, 64'h14, 64'd0, 64'hFFFF_FFFF_8877_6655, 1'b0, 3, 1'b1, a0);
    issue(1'b0, 3'd6, 64'h14, 64'd0, 64'h0000_0000_8877_6655, 1'b0, 3, 1'b1, a0);
    issue(1'b0, 3'd5, 64'h16, 64'd0, 64'h0000_0000_0000_8877, 1'b0, 3, 1'b1, a0);
    drain();
    check_val("loads_no_write", 64'(wr_cnt), 64'(w0));

    // Halfword store: single write three cycles after accept.
    w0 = wr_cnt;
    issue(1'b1, 3'd1, 64'h12, 64'hDEAD_BEEF_0000_ABCD, 64'd0, 1'b0, 4, 1'b1, a0);
    drain();
    check_val("sh_write_count", 64'(wr_cnt), 64'(w0 + 1));
    check_val("sh_write_cycle", 64'(last_wr_cyc), 64'(a0 + 3));
    check_val("sh_mem_word", mem[2], 64'h8877_6655_ABCD_2211);

    // High address bits wrap onto the same word.
    issue(1'b0, 3'd3, 64'h0000_0100_0000_0010, 64'd0, 64'h8877_6655_ABCD_2211, 1'b0, 3, 1'b1, a0);

    // Byte and word merges, read back as a doubleword.
    issue(1'b1, 3'd0, 64'h21, 64'hFFFF_FFFF_FFFF_FF5A, 64'd0, 1'b0, 4, 1'b1, a0);
    issue(1'b1, 3'd2, 64'h24, 64'h1234_5678_CAFE_F00D, 64'd0, 1'b0, 4, 1'b1, a0);
    issue(1'b0, 3'd3, 64'h20, 64'd0, 64'hCAFE_F00D_89AB_5AEF, 1'b0, 3, 1'b1, a0);
    drain();

    // Misaligned and illegal requests: immediate error, no memory traffic.
    w0 = wr_cnt;
    issue(1'b0, 3'd2, 64'h06, 64'd0, 64'd0, 1'b1, 1, 1'b1, a0);
    issue(1'b0, 3'd7, 64'h10, 64'd0, 64'd0, 1'b1, 1, 1'b1, a0);
    issue(1'b1, 3'd1, 64'h13, 64'hFFFF, 64'd0, 1'b1, 1, 1'b1, a0);
    issue(1'b1, 3'd4, 64'h10, 64'hFFFF, 64'd0, 1'b1, 1, 1'b1, a0);
    issue(1'b1, 3'd3, 64'h1C, 64'hFFFF, 64'd0, 1'b1, 1, 1'b1, a0);
    issue(1'b0, 3'd3, 64'h11, 64'd0, 64'd0, 1'b1, 1, 1'b1, a0);
    drain();
    check_val("err_no_write", 64'(wr_cnt), 64'(w0));
    check_val("err_mem_kept", mem[2], 64'h8877_6655_ABCD_2211);

    // SD followed by LD accepted in the SD response cycle.
    issue(1'b1, 3'd3, 64'h18, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 2, 1'b1, a0);
    issue(1'b0, 3'd3, 64'h18, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 3, 1'b1, a1);
    check_val("b2b_accept_cycle", 64'(a1), 64'(a0 + 2));
    drain();

    // Reset during the CAP cycle, then during the WR cycle, of a byte store.
    reset_during(2);
    reset_during(3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
